// File: rtl/mem_pkg.sv
// Definitions shared by the data memory, the controller and the copy engine:
// memory-port status codes and the engine state encoding.
package mem_pkg;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } eng_state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-copy / block-fill initiator on the data memory port. Address and write
// data are registered so the port never depends combinationally on Start.
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Fill,
  input  logic [W-1:0] SrcAddr,
  input  logic [W-1:0] DstAddr,
  input  logic [W:0]   Length,
  input  logic [7:0]   FillValue,
  input  logic [7:0]   MemDataOut,
  output logic [W-1:0] DataAddress,
  output logic [1:0]   MemStatus,
  output logic [7:0]   MemDataIn,
  output logic         Busy,
  output logic         Done
);

  eng_state_e   state_q, state_d;
  logic [W-1:0] src_q, src_d;
  logic [W-1:0] dst_q, dst_d;
  logic [W:0]   rem_q, rem_d;
  logic         fill_q, fill_d;
  logic [W-1:0] addr_q, addr_d;
  logic [7:0]   wdata_q, wdata_d;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // addr_d/wdata_d are loaded with the value the *next* state presents, so
  // the port holds its last value through DONE and IDLE.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          src_d  = SrcAddr;
          dst_d  = DstAddr;
          rem_d  = Length;
          fill_d = Fill;
          if (Length == '0) begin
            state_d = ST_DONE;
          end else if (Fill) begin
            state_d = ST_WR;
            addr_d  = DstAddr;
            wdata_d = FillValue;
          end else begin
            state_d = ST_RD;
            addr_d  = SrcAddr;
          end
        end
      end
      ST_RD: begin
        // wdata_q doubles as the copy data register; in fill mode it keeps FillValue.
        wdata_d = MemDataOut;
        addr_d  = dst_q;
        state_d = ST_WR;
      end
      ST_WR: begin
        src_d = src_q + 1'b1;
        dst_d = dst_q + 1'b1;
        rem_d = rem_q - 1'b1;
        if (rem_q == {{W{1'b0}}, 1'b1}) begin
          state_d = ST_DONE;
        end else if (fill_q) begin
          addr_d = dst_q + 1'b1;
        end else begin
          state_d = ST_RD;
          addr_d  = src_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    MemStatus = MEM_IDLE;
    if (state_q == ST_RD) MemStatus = MEM_LOAD;
    if (state_q == ST_WR) MemStatus = MEM_STORE;
  end

  assign DataAddress = addr_q;
  assign MemDataIn   = wdata_q;
  assign Busy        = (state_q == ST_RD) || (state_q == ST_WR);
  assign Done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized scoreboard bench: a byte-array reference model predicts the
// load/store stream, Done cycle and final memory image of each transfer.
module tb_mem_copy_engine;

  logic       CLK = 1'b0;
  logic       Reset, Start, Fill;
  logic [7:0] SrcAddr, DstAddr, FillValue, MemDataOut, DataAddress, MemDataIn;
  logic [8:0] Length;
  logic [1:0] MemStatus;
  logic       Busy, Done;

  mem_copy_engine #(.W(8)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Fill(Fill),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length), .FillValue(FillValue),
    .MemDataOut(MemDataOut), .DataAddress(DataAddress), .MemStatus(MemStatus),
    .MemDataIn(MemDataIn), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  assign MemDataOut = mem[DataAddress];
  always @(posedge CLK) if (MemStatus == 2'b10) mem[DataAddress] <= MemDataIn;

  logic [7:0]  exp_load [$];
  logic [15:0] exp_store [$];
  int          exp_done [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  bit          mon_en = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the engine drives the port or pulses Done.
  logic [7:0]  le;
  logic [15:0] se;
  int          de;
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("busy_vs_status", Busy, (MemStatus == 2'b01) || (MemStatus == 2'b10));
      if (MemStatus == 2'b01) begin
        chk("load_expected", exp_load.size() != 0, 1);
        if (exp_load.size() != 0) begin
          le = exp_load.pop_front();
          chk("load_addr", DataAddress, le);
        end
      end else if (MemStatus == 2'b10) begin
        chk("store_expected", exp_store.size() != 0, 1);
        if (exp_store.size() != 0) begin
          se = exp_store.pop_front();
          chk("store_addr", DataAddress, se[15:8]);
          chk("store_data", MemDataIn, se[7:0]);
        end
      end else if (MemStatus == 2'b11) begin
        chk("status_code", MemStatus, 2'b00);
      end
      if (Done) begin
        chk("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) begin
          de = exp_done.pop_front();
          chk("done_cycle", cyc - start_cyc + 1, de);
        end
      end
    end
  end

  task automatic check_mem(input string name);
    int bad = -1;
    for (int i = 0; i < 256; i++) if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
    if (bad < 0) chk(name, 0, 0);
    else chk({name, "_byte"}, {bad[7:0], mem[bad]}, {bad[7:0], ref_mem[bad]});
  endtask

  task automatic run_xfer(input bit fill, input logic [7:0] src, input logic [7:0] dst,
                          input logic [8:0] len, input logic [7:0] fv, input bit noisy);
    int n = int'(len);
    bit done_seen = 0;
    logic [7:0] s, d, v;
    @(negedge CLK);
    Fill = fill; SrcAddr = src; DstAddr = dst; Length = len; FillValue = fv; Start = 1'b1;
    for (int i = 0; i < n; i++) begin
      s = src + 8'(i);
      d = dst + 8'(i);
      v = fill ? fv : ref_mem[s];
      if (!fill) exp_load.push_back(s);
      exp_store.push_back({d, v});
      ref_mem[d] = v;
    end
    exp_done.push_back(n == 0 ? 1 : (fill ? n + 1 : 2 * n + 1));
    @(posedge CLK);
    #1;
    start_cyc = cyc;
    Start = 1'b0;
    for (int k = 0; k < 2 * n + 8 && !done_seen; k++) begin
      @(negedge CLK);
      if (Done) done_seen = 1;
      if (noisy) begin
        Start = 1'($urandom); Fill = 1'($urandom); SrcAddr = 8'($urandom);
        DstAddr = 8'($urandom); Length = 9'($urandom_range(0, 256)); FillValue = 8'($urandom);
      end
    end
    @(posedge CLK);
    #1 Start = 1'b0;
    chk("done_seen", done_seen, 1);
    repeat (2) @(negedge CLK);
    check_mem("mem_image");
    chk("queues_drained", exp_load.size() + exp_store.size() + exp_done.size(), 0);
    exp_load.delete(); exp_store.delete(); exp_done.delete();
    $display("xfer %s src=%02h dst=%02h len=%0d fv=%02h noisy=%0d errors_so_far=%0d",
             fill ? "fill" : "copy", src, dst, len, fv, noisy, errors);
  endtask

  // Copy of 8 bytes aborted by Reset during cycle 5: only bytes 0-1 are stored.
  task automatic run_abort(input logic [7:0] src, input logic [7:0] dst);
    @(negedge CLK);
    Fill = 1'b0; SrcAddr = src; DstAddr = dst; Length = 9'd8; FillValue = 8'h00; Start = 1'b1;
    for (int i = 0; i < 3; i++) exp_load.push_back(src + 8'(i));
    for (int i = 0; i < 2; i++) begin
      exp_store.push_back({dst + 8'(i), ref_mem[src + 8'(i)]});
      ref_mem[dst + 8'(i)] = ref_mem[src + 8'(i)];
    end
    @(posedge CLK);
    #1;
    start_cyc = cyc;
    Start = 1'b0;
    repeat (4) @(posedge CLK);
    #1 Reset = 1'b1;
    @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    chk("abort_status", MemStatus, 2'b00);
    chk("abort_busy", Busy, 0);
    repeat (3) @(negedge CLK);
    check_mem("abort_mem_image");
    chk("abort_queues_drained", exp_load.size() + exp_store.size(), 0);
    exp_load.delete(); exp_store.delete(); exp_done.delete();
    $display("xfer abort src=%02h dst=%02h len=8 errors_so_far=%0d", src, dst, errors);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
    mem[8'h20] = 8'h11;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    Reset = 1'b1; Start = 1'b1; Fill = 1'b0; SrcAddr = 8'h33; DstAddr = 8'h44;
    Length = 9'd5; FillValue = 8'h77;
    @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("reset_busy", Busy, 0);
      chk("reset_done", Done, 0);
      chk("reset_status", MemStatus, 2'b00);
      chk("reset_addr", DataAddress, 8'h00);
      chk("reset_wdata", MemDataIn, 8'h00);
    end
    @(posedge CLK);
    #1 Reset = 1'b0; Start = 1'b0;
    mon_en = 1;

    run_xfer(1'b0, 8'h10, 8'h40, 9'd4, 8'h00, 1'b0);
    chk("copy_byte0", mem[8'h40], 8'hAA);
    chk("copy_byte3", mem[8'h43], 8'hDD);
    run_xfer(1'b1, 8'h00, 8'hFE, 9'd3, 8'h5A, 1'b0);
    chk("fill_wrap_byte", mem[8'h00], 8'h5A);
    run_xfer(1'b0, 8'h50, 8'h60, 9'd0, 8'h00, 1'b1);
    run_xfer(1'b1, 8'h50, 8'h60, 9'd0, 8'h99, 1'b1);
    run_abort(8'h80, 8'h90);
    run_xfer(1'b0, 8'h20, 8'h21, 9'd3, 8'h00, 1'b1);
    chk("overlap_byte3", mem[8'h23], 8'h11);
    for (int t = 0; t < 12; t++)
      run_xfer(1'($urandom), 8'($urandom), 8'($urandom), 9'($urandom_range(0, 20)),
               8'($urandom), 1'($urandom));
    run_xfer(1'b1, 8'h00, 8'hC3, 9'd256, 8'hE7, 1'b1);
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    run_xfer(1'b0, 8'h05, 8'h85, 9'd256, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
